data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 6 +
 rtl/data_mem_ram.sv | 24 ++
 rtl/data_mem_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM state type and fault fill patterns for the data memory controller.
package data_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam logic [31:0] DEAD_BEEF = 32'hdead_beef;
    localparam logic [31:0] FAIL_LEAF = 32'hfa11_1eaf;
endpackage

// File: rtl/data_mem_ram.sv
// data_mem_ram: word storage with byte-strobed synchronous write and registered, enable-gated read.
module data_mem_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int b = 0; b < DATA_W/8; b++)
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        if (re_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory controller with READ_LATENCY-cycle reads and range faults.
// Define DATA_MEM_ALIGN_CHECK_EN to also fault on misaligned byte addresses.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_req_i,
    input  logic                write_enable_i,
    input  logic [DATA_W/8-1:0] byte_enable_i,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   write_data_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   read_data_o,
    output logic                valid_o,
    output logic                error_o
);
    localparam int BPW  = DATA_W / 8;
    localparam int OFF  = $clog2(BPW);
    localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW   = $clog2(READ_LATENCY + 1);
    localparam int NREP = (DATA_W + 31) / 32;
    localparam logic [NREP*32-1:0] DEAD_REP = {NREP{DEAD_BEEF}};
    localparam logic [NREP*32-1:0] FAIL_REP = {NREP{FAIL_LEAF}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rerr_q, rmis_q, werr_q;
    logic [DATA_W-1:0] last_q, ram_rdata, resp_data;
    logic [31:0]       idx;
    logic              oob, misalign, fault, rd_acc, wr_acc;

    assign idx = addr_i >> OFF;
    assign oob = idx >= 32'(DEPTH_WORDS);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam logic [31:0] ALIGN_MASK = 32'(BPW - 1);
    assign misalign = |(addr_i & ALIGN_MASK);
`else
    assign misalign = 1'b0;
`endif
    assign fault   = oob || misalign;
    assign ready_o = state_q != WAIT;
    assign rd_acc  = mem_req_i && ready_o && !write_enable_i;
    assign wr_acc  = mem_req_i && ready_o && write_enable_i;

    // Read data is captured inside the RAM at acceptance and held there until the next accepted read.
    data_mem_ram #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk_i  (clk_i),
        .we_i   (wr_acc && !fault),
        .be_i   (byte_enable_i),
        .addr_i (idx[AW-1:0]),
        .wdata_i(write_data_i),
        .re_i   (rd_acc && !fault),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == WAIT) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? RESP : WAIT;
        end else if (rd_acc) begin
            cnt_d   = CW'(READ_LATENCY - 1);
            state_d = (READ_LATENCY == 1) ? RESP : WAIT;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
            rmis_q  <= 1'b0;
            werr_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            werr_q  <= wr_acc && fault;
            if (rd_acc) begin
                rerr_q <= fault;
                rmis_q <= !oob;
            end
            if (valid_o) last_q <= resp_data;
        end
    end

    assign valid_o     = state_q == RESP;
    assign resp_data   = rerr_q ? (rmis_q ? FAIL_REP[DATA_W-1:0] : DEAD_REP[DATA_W-1:0]) : ram_rdata;
    assign read_data_o = valid_o ? resp_data : last_q;
    assign error_o     = (valid_o && rerr_q) || werr_q;
endmodule
